// File: rtl/regfile_pkg.sv
// Shared types for the register-file write arbiter: FSM state encoding and
// a width helper that never returns zero.
package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Index/address width for n items; a single item still needs one bit.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// searching upward from ptr+1 with wrap-around.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = addr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  always_comb begin
    int idx;
    valid     = 1'b0;
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for the latch-based register file; each write
// runs SETUP/STROBE/HOLD. Define REGFILE_ARB_ZERO_REG_EN to hardwire register 0.
//
// state  | meaning
// IDLE   | no write in flight, arbitrate incoming requests
// SETUP  | captured data driven on wr_data, no strobe yet
// STROBE | one-hot set pulse for the captured address
// HOLD   | data held after the strobe, ack pulses, may chain the next write
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter  int BIT_WIDTH  = 32,
  parameter  int NUM_REGS   = 32,
  parameter  int NUM_REQ    = 4,
  localparam int ADDR_WIDTH = addr_width(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]              ack,
  output logic [BIT_WIDTH-1:0]            wr_data,
  output logic [NUM_REGS-1:0]             wr_set,
  output logic                            busy
);

  localparam int IDX_W = addr_width(NUM_REQ);

`ifdef REGFILE_ARB_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0]      grant_oh_q, grant_oh_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BIT_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [NUM_REGS-1:0]     wr_set_q, wr_set_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    busy_q, busy_d;

  logic [NUM_REQ-1:0]      arb_req;
  logic [IDX_W-1:0]        arb_ptr;
  logic                    arb_valid;
  logic [NUM_REQ-1:0]      arb_grant;
  logic [IDX_W-1:0]        arb_idx;
  logic                    capture;

  function automatic logic [NUM_REGS-1:0] set_decode(input logic [ADDR_WIDTH-1:0] a);
    logic [NUM_REGS-1:0] s;
    s = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (int'(a) == r) s[r] = 1'b1;
    end
    if (ZERO_REG_EN) s[0] = 1'b0;
    return s;
  endfunction

  // In HOLD the requester being acked is masked out and the pointer is
  // already advanced to it, so chained writes stay fair.
  always_comb begin
    arb_req = req;
    arb_ptr = ptr_q;
    if (state_q == HOLD) begin
      arb_req = req & ~grant_oh_q;
      arb_ptr = grant_idx_q;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req       (arb_req),
    .ptr       (arb_ptr),
    .valid     (arb_valid),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    grant_oh_d  = grant_oh_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    capture     = 1'b0;

    case (state_q)
      IDLE:    capture = arb_valid;
      SETUP:   state_d = STROBE;
      STROBE:  state_d = HOLD;
      HOLD: begin
        ptr_d = grant_idx_q;
        if (arb_valid) capture = 1'b1;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      state_d     = SETUP;
      grant_idx_d = arb_idx;
      grant_oh_d  = arb_grant;
      addr_d      = req_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
      wr_data_d   = req_data[arb_idx*BIT_WIDTH +: BIT_WIDTH];
    end

    // Outputs are registered, so they are computed for the state being entered.
    wr_set_d = (state_d == STROBE) ? set_decode(addr_q) : '0;
    ack_d    = (state_d == HOLD) ? grant_oh_q : '0;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wr_set_q    <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_oh_q  <= grant_oh_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wr_set_q    <= wr_set_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign wr_data = wr_data_q;
  assign wr_set  = wr_set_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (NUM_REGS=24, NUM_REQ=4); honours
// REGFILE_ARB_ZERO_REG_EN for the register-0 expectation.
module tb_regfile_write_arbiter;

  localparam int BW = 32;
  localparam int NR = 24;
  localparam int NQ = 4;
  localparam int AW = 5;

`ifdef REGFILE_ARB_ZERO_REG_EN
  localparam logic [NR-1:0] ZERO_SET = '0;
`else
  localparam logic [NR-1:0] ZERO_SET = 24'h1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NQ-1:0]     req = '0;
  logic [NQ*AW-1:0]  req_addr = '0;
  logic [NQ*BW-1:0]  req_data = '0;
  logic [NQ-1:0]     ack;
  logic [BW-1:0]     wr_data;
  logic [NR-1:0]     wr_set;
  logic              busy;

  regfile_write_arbiter #(
    .BIT_WIDTH (BW),
    .NUM_REGS  (NR),
    .NUM_REQ   (NQ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .wr_data  (wr_data),
    .wr_set   (wr_set),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NQ-1:0] ack;
    logic [BW-1:0] data;
    logic [NR-1:0] set;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [NQ-1:0] a, input logic [BW-1:0] d,
                      input logic [NR-1:0] s, input int c);
    exp_t e;
    e.ack = a; e.data = d; e.set = s; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [BW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*BW +: BW] = d;
  endtask

  task automatic wait_acks(input int n, input int budget);
    int seen = 0;
    for (int i = 0; i < budget && seen < n; i++) begin
      @(negedge clk);
      if (ack != '0) seen++;
    end
    if (seen < n) chk("ack_timeout", 64'(seen), 64'(n));
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each ack.
  logic [NR-1:0] seen_set = '0;
  int            set_cycles = 0;
  logic [BW-1:0] d1 = '0, d2 = '0;

  always @(negedge clk) begin
    if (rst) begin
      seen_set   = '0;
      set_cycles = 0;
    end else begin
      chk("wr_set_onehot0", 64'($onehot0(wr_set)), 64'd1);
      chk("ack_onehot0", 64'($onehot0(ack)), 64'd1);
      if (wr_set != '0) begin
        chk("set_needs_busy_no_ack", {busy, ack}, {1'b1, 4'b0});
        seen_set |= wr_set;
        set_cycles++;
      end
      if (ack != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_ack", 64'(ack), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("ack_bits", 64'(ack), 64'(e.ack));
          chk("ack_cycle", 64'(cyc), 64'(e.cyc));
          chk("data_hold", 64'(wr_data), 64'(e.data));
          chk("data_strobe", 64'(d1), 64'(e.data));
          chk("data_setup", 64'(d2), 64'(e.data));
          chk("set_bits", 64'(seen_set), 64'(e.set));
          chk("set_cycles", 64'(set_cycles), (e.set != '0) ? 64'd1 : 64'd0);
          chk("busy_in_hold", 64'(busy), 64'd1);
        end
        seen_set   = '0;
        set_cycles = 0;
      end
      d2 = d1;
      d1 = wr_data;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    @(negedge clk);
    @(negedge clk);
    chk("reset_wr_set", 64'(wr_set), 64'd0);
    chk("reset_wr_data", 64'(wr_data), 64'd0);
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single write, requester 0, addr 5.
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    req = 4'b0001;
    c = cyc;
    push(4'b0001, 32'hDEAD_BEEF, 24'h1 << 5, c + 3);
    wait_acks(1, 10);
    req = '0;
    @(negedge clk);
    chk("busy_after_single", 64'(busy), 64'd0);
    chk("wr_data_kept_idle", 64'(wr_data), 64'hDEAD_BEEF);

    // All four requesting from reset: order 0,1,2,3,0, three cycles apart.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NQ; i++) set_req(i, AW'(10 + i), 32'hC0DE_0000 + i);
    req = 4'b1111;
    rst = 1'b0;
    c = cyc;
    push(4'b0001, 32'hC0DE_0000, 24'h1 << 10, c + 3);
    push(4'b0010, 32'hC0DE_0001, 24'h1 << 11, c + 6);
    push(4'b0100, 32'hC0DE_0002, 24'h1 << 12, c + 9);
    push(4'b1000, 32'hC0DE_0003, 24'h1 << 13, c + 12);
    push(4'b0001, 32'hC0DE_0000, 24'h1 << 10, c + 15);
    wait_acks(5, 40);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    // Requester 2 drops req and changes addr/data right after grant.
    set_req(2, 5'd7, 32'hA5A5_0002);
    req = 4'b0100;
    c = cyc;
    push(4'b0100, 32'hA5A5_0002, 24'h1 << 7, c + 3);
    @(negedge clk);
    req = '0;
    set_req(2, 5'd3, 32'hFFFF_FFFF);
    wait_acks(1, 10);
    @(negedge clk);
    @(negedge clk);

    // Out-of-range address: no strobe, ack still pulses.
    set_req(1, 5'd30, 32'h1234_5678);
    req = 4'b0010;
    c = cyc;
    push(4'b0010, 32'h1234_5678, '0, c + 3);
    wait_acks(1, 10);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    // Address 0: strobe depends on the zero-register option.
    set_req(3, 5'd0, 32'h0000_00FF);
    req = 4'b1000;
    c = cyc;
    push(4'b1000, 32'h0000_00FF, ZERO_SET, c + 3);
    wait_acks(1, 10);
    req = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset during STROBE aborts the write without an ack.
    set_req(0, 5'd9, 32'h0BAD_0009);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("strobe_before_abort", 64'(wr_set), 64'(24'h1 << 9));
    #2 rst = 1'b1;
    #1;
    chk("abort_wr_set", 64'(wr_set), 64'd0);
    chk("abort_ack", 64'(ack), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < NQ; i++) set_req(i, AW'(10 + i), 32'h5EED_0000 + i);
    req = 4'b1111;
    rst = 1'b0;
    c = cyc;
    push(4'b0001, 32'h5EED_0000, 24'h1 << 10, c + 3);
    wait_acks(1, 10);
    req = '0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
